// File: rtl/trs80_uart_tx.sv
// Double-buffered asynchronous serial transmitter for the TRS-80 RS-232 port.
// The frame format (baud, word length, parity, stop bits) is latched from cfg at each transfer.
module trs80_uart_tx #(
  parameter int unsigned CLK_HZ = 42_000_000
) (
  input  logic       clk42,
  input  logic       reset_n,
  input  logic [7:0] cfg,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  input  logic       uart_cts,
  output logic       tx_thre,
  output logic       tx_tre,
  output logic       uart_tx
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Bit-timer reload values: one bit lasts DIV clocks, so the timer counts DIV-1 down to 0.
  function automatic logic [18:0] div_m1(input logic [2:0] baud);
    logic [18:0] d;
    case (baud)
      3'd0:    d = 19'(CLK_HZ / 32'd9600 - 32'd1);
      3'd1:    d = 19'(CLK_HZ / 32'd4800 - 32'd1);
      3'd2:    d = 19'(CLK_HZ / 32'd2400 - 32'd1);
      3'd3:    d = 19'(CLK_HZ / 32'd1200 - 32'd1);
      3'd4:    d = 19'(CLK_HZ / 32'd600 - 32'd1);
      3'd5:    d = 19'(CLK_HZ / 32'd300 - 32'd1);
      3'd6:    d = 19'(CLK_HZ / 32'd150 - 32'd1);
      default: d = 19'(CLK_HZ / 32'd110 - 32'd1);
    endcase
    return d;
  endfunction

  // Word length code 0..3 selects 8..5 data bits; higher bits are masked out of parity.
  function automatic logic parity_of(input logic [7:0] data, input logic [1:0] wlen,
                                     input logic odd);
    logic [7:0] mask;
    mask = 8'hFF >> wlen;
    return (^(data & mask)) ^ odd;
  endfunction

  state_t      state_r, state_nx_s;
  logic [18:0] timer_r, timer_nx_s;
  logic [2:0]  bit_r, bit_nx_s;
  logic [7:0]  shift_r, shift_nx_s;
  logic [7:0]  fcfg_r, fcfg_nx_s;
  logic [7:0]  hold_r, hold_nx_s;
  logic        par_r, par_nx_s;
  logic        thre_r, thre_nx_s;
  logic        tre_r;
  logic        tx_r, tx_nx_s;
  logic        cts_meta_r, cts_s;
  logic        xfer_ok_s, xfer_s;
  logic [18:0] bit_div_s;
  logic [2:0]  last_bit_s;

  assign xfer_ok_s  = ~thre_r & ~cts_s;
  assign bit_div_s  = div_m1(fcfg_r[2:0]);
  assign last_bit_s = 3'd7 - {1'b0, fcfg_r[6:5]};

  // Next-state, holding-register and serial-line logic.
  always_comb begin
    state_nx_s = state_r;
    timer_nx_s = timer_r;
    bit_nx_s   = bit_r;
    shift_nx_s = shift_r;
    fcfg_nx_s  = fcfg_r;
    par_nx_s   = par_r;
    hold_nx_s  = hold_r;
    thre_nx_s  = thre_r;
    xfer_s     = 1'b0;
    tx_nx_s    = 1'b1;

    if (tx_load && thre_r) begin
      hold_nx_s = tx_data;
      thre_nx_s = 1'b0;
    end else begin
      hold_nx_s = hold_r;
    end

    case (state_r)
      S_IDLE: begin
        xfer_s = xfer_ok_s;
      end
      S_START: begin
        if (timer_r == 19'd0) begin
          state_nx_s = S_DATA;
          timer_nx_s = bit_div_s;
          bit_nx_s   = 3'd0;
        end else begin
          timer_nx_s = timer_r - 19'd1;
        end
      end
      S_DATA: begin
        if (timer_r == 19'd0) begin
          timer_nx_s = bit_div_s;
          if (bit_r == last_bit_s) begin
            bit_nx_s   = 3'd0;
            state_nx_s = fcfg_r[3] ? S_PARITY : S_STOP;
          end else begin
            bit_nx_s   = bit_r + 3'd1;
            shift_nx_s = {1'b0, shift_r[7:1]};
          end
        end else begin
          timer_nx_s = timer_r - 19'd1;
        end
      end
      S_PARITY: begin
        if (timer_r == 19'd0) begin
          state_nx_s = S_STOP;
          timer_nx_s = bit_div_s;
          bit_nx_s   = 3'd0;
        end else begin
          timer_nx_s = timer_r - 19'd1;
        end
      end
      S_STOP: begin
        if (timer_r == 19'd0) begin
          // Last stop bit done: chain straight into the next frame when one is ready.
          if (fcfg_r[4] || (bit_r == 3'd1)) begin
            if (xfer_ok_s) begin
              xfer_s = 1'b1;
            end else begin
              state_nx_s = S_IDLE;
            end
          end else begin
            bit_nx_s   = bit_r + 3'd1;
            timer_nx_s = bit_div_s;
          end
        end else begin
          timer_nx_s = timer_r - 19'd1;
        end
      end
      default: begin
        state_nx_s = S_IDLE;
      end
    endcase

    if (xfer_s) begin
      state_nx_s = S_START;
      shift_nx_s = hold_r;
      fcfg_nx_s  = cfg;
      par_nx_s   = parity_of(hold_r, cfg[6:5], cfg[7]);
      timer_nx_s = div_m1(cfg[2:0]);
      bit_nx_s   = 3'd0;
      thre_nx_s  = 1'b1;
    end else begin
      thre_nx_s  = thre_nx_s;
    end

    case (state_nx_s)
      S_START:  tx_nx_s = 1'b0;
      S_DATA:   tx_nx_s = shift_nx_s[0];
      S_PARITY: tx_nx_s = par_nx_s;
      default:  tx_nx_s = 1'b1;
    endcase
  end

  // State, datapath and output registers; reset idles the line high.
  always_ff @(posedge clk42 or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= S_IDLE;
      timer_r    <= 19'd0;
      bit_r      <= 3'd0;
      shift_r    <= 8'd0;
      fcfg_r     <= 8'd0;
      hold_r     <= 8'd0;
      par_r      <= 1'b0;
      thre_r     <= 1'b1;
      tre_r      <= 1'b1;
      tx_r       <= 1'b1;
      cts_meta_r <= 1'b0;
      cts_s      <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      timer_r    <= timer_nx_s;
      bit_r      <= bit_nx_s;
      shift_r    <= shift_nx_s;
      fcfg_r     <= fcfg_nx_s;
      hold_r     <= hold_nx_s;
      par_r      <= par_nx_s;
      thre_r     <= thre_nx_s;
      tre_r      <= thre_r & (state_r == S_IDLE);
      tx_r       <= tx_nx_s;
      cts_meta_r <= uart_cts;
      cts_s      <= cts_meta_r;
    end
  end

  assign tx_thre = thre_r;
  assign tx_tre  = tre_r;
  assign uart_tx = tx_r;

endmodule

// File: tb/tb_trs80_uart_tx.sv
// Randomised and directed bench for trs80_uart_tx, checked cycle by cycle against a
// frame-level model that expands each transferred byte into its expected line levels.
module tb_trs80_uart_tx;

  localparam int unsigned TB_CLK_HZ = 96000;

  logic       clk42 = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] cfg = 8'h00;
  logic [7:0] tx_data = 8'h00;
  logic       tx_load = 1'b0;
  logic       uart_cts = 1'b0;
  logic       tx_thre, tx_tre, uart_tx;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  bit         wave_q[$];
  bit         m_full = 1'b0;
  bit         m_idle = 1'b1;
  logic [7:0] m_hold = 8'h00;
  bit         m_c1 = 1'b0, m_c2 = 1'b0;
  bit         exp_tx = 1'b1, exp_thre = 1'b1, exp_tre = 1'b1;

  trs80_uart_tx #(.CLK_HZ(TB_CLK_HZ)) dut (
    .clk42(clk42), .reset_n(reset_n), .cfg(cfg), .tx_data(tx_data), .tx_load(tx_load),
    .uart_cts(uart_cts), .tx_thre(tx_thre), .tx_tre(tx_tre), .uart_tx(uart_tx)
  );

  always #5 clk42 = ~clk42;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic int div_of(input logic [2:0] b);
    int rates[8] = '{9600, 4800, 2400, 1200, 600, 300, 150, 110};
    return TB_CLK_HZ / rates[b];
  endfunction

  task automatic push_bit(input bit v, input int dv);
    repeat (dv) wave_q.push_back(v);
  endtask

  task automatic build_frame(input logic [7:0] d, input logic [7:0] c);
    int n, ones, dv;
    n = 8 - int'(c[6:5]);
    dv = div_of(c[2:0]);
    ones = 0;
    push_bit(1'b0, dv);
    for (int i = 0; i < n; i++) begin
      push_bit(d[i], dv);
      ones += int'(d[i]);
    end
    if (c[3]) push_bit(bit'(ones % 2) ^ c[7], dv);
    push_bit(1'b1, dv);
    if (!c[4]) push_bit(1'b1, dv);
  endtask

  task automatic model_reset();
    wave_q.delete();
    m_full = 1'b0; m_idle = 1'b1; m_c1 = 1'b0; m_c2 = 1'b0;
    exp_tx = 1'b1; exp_thre = 1'b1; exp_tre = 1'b1;
  endtask

  // Predict outputs after the coming clock edge from the inputs currently applied.
  task automatic model_step();
    bit pre_thre, pre_idle, pre_empty, xfer;
    pre_thre  = !m_full;
    pre_idle  = m_idle;
    pre_empty = (wave_q.size() == 0);
    xfer      = pre_empty && m_full && !m_c2;
    if (xfer) begin
      build_frame(m_hold, cfg);
      m_full = 1'b0;
    end else if (tx_load && pre_thre) begin
      m_hold = tx_data;
      m_full = 1'b1;
    end
    exp_tre  = pre_thre && pre_idle;
    m_idle   = pre_empty && !xfer;
    exp_tx   = (wave_q.size() != 0) ? wave_q.pop_front() : 1'b1;
    m_c2     = m_c1;
    m_c1     = uart_cts;
    exp_thre = !m_full;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk42);
    #1;
    check_eq("uart_tx", 32'(uart_tx), 32'(exp_tx));
    check_eq("tx_thre", 32'(tx_thre), 32'(exp_thre));
    check_eq("tx_tre", 32'(tx_tre), 32'(exp_tre));
    @(negedge clk42);
    tx_load = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic load(input logic [7:0] d);
    tx_data = d;
    tx_load = 1'b1;
    tick();
  endtask

  task automatic run_until_idle(input int max_cyc);
    int n;
    n = 0;
    while (!(tx_tre && m_idle && !m_full) && n < max_cyc) begin
      tick();
      n++;
    end
    check_eq("idle_bound", 32'(tx_tre), 32'd1);
    ticks(3);
  endtask

  initial begin
    logic [7:0] c_v;
    // Reset state
    #12;
    check_eq("rst_tx", 32'(uart_tx), 32'd1);
    check_eq("rst_thre", 32'(tx_thre), 32'd1);
    check_eq("rst_tre", 32'(tx_tre), 32'd1);
    @(negedge clk42);
    reset_n = 1'b1;
    ticks(3);

    // Basic 8N2 frame
    cfg = 8'h00; load(8'h55); run_until_idle(500);

    // 7E1 / 7O1 parity, bit 7 ignored
    cfg = 8'h38; load(8'h41); run_until_idle(500);
    cfg = 8'hB8; load(8'h41); run_until_idle(500);
    cfg = 8'h38; load(8'hC1); run_until_idle(500);

    // Back-to-back with a dropped third load
    cfg = 8'h10;
    load(8'hA1); ticks(3);
    load(8'h5B); load(8'hFF); ticks(20); load(8'h77);
    run_until_idle(1000);

    // Flow control
    uart_cts = 1'b1; ticks(4);
    load(8'h12); ticks(60);
    uart_cts = 1'b0; ticks(40);
    uart_cts = 1'b1; run_until_idle(500);
    uart_cts = 1'b0; ticks(4);

    // 110 baud frame with cfg changed mid-frame, then a queued frame at the new rate
    cfg = 8'h17; load(8'h3C); ticks(2000);
    cfg = 8'h00; load(8'hC3);
    run_until_idle(12000);

    // Randomised frames, load timing and CTS
    for (int k = 0; k < 25; k++) begin
      c_v = 8'($urandom_range(0, 255));
      c_v[2:0] = 3'($urandom_range(0, 2));
      cfg = c_v;
      load(8'($urandom_range(0, 255)));
      uart_cts = ($urandom_range(0, 7) == 0);
      ticks($urandom_range(0, 300));
      uart_cts = 1'b0;
    end
    run_until_idle(3000);

    // Reset mid-frame with a byte queued
    cfg = 8'h10; load(8'hA5); ticks(2);
    load(8'h3C); ticks(15);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_eq("rstmid_tx", 32'(uart_tx), 32'd1);
    check_eq("rstmid_thre", 32'(tx_thre), 32'd1);
    check_eq("rstmid_tre", 32'(tx_tre), 32'd1);
    @(negedge clk42);
    reset_n = 1'b1;
    ticks(300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
